vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
- Sequences stored test vectors into a bank of per-pin force-format registers; each vector holds a data bit and a 2-bit force-format code per pin.
- Latches one timing set per run: cycle length, leading edge and trailing edge.
- Mirrors the pin registers' tick count, so each vector is held stable for exactly one tester cycle.
- Controls the pin bank through its enable and reset, reads vectors from a synchronous vector RAM, and reports run status to the host control logic.

Parameters:
- NUM_PINS, 8, number of driven pins.
- ADDR_W, 10, vector RAM address width.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- START  in  1  one-clock pulse; honoured only in IDLE.
- ABORT  in  1  one-clock pulse; stops a run from any non-IDLE state.
- CYCLE_LENGTH  in  8  clocks per tester cycle.
- LEADING_EDGE  in  7  leading-edge tick.
- TRAILING_EDGE  in  7  trailing-edge tick.
- NUM_VECTORS  in  ADDR_W+1  number of vectors to apply.
- VEC_RD  out  1  RAM read strobe.
- VEC_ADDR  out  ADDR_W  RAM read address.
- VEC_DATA  in  3*NUM_PINS  RAM data, valid 1 clock after VEC_RD. Pin i: D at bit i, FF at bits [NUM_PINS+2i+1 : NUM_PINS+2i].
- PIN_EN  out  1  enable to the pin bank.
- PIN_RST  out  1  reset to the pin bank.
- PIN_D  out  NUM_PINS  applied data bits.
- PIN_FF  out  2*NUM_PINS  applied force-format codes.
- CL_OUT / LE_OUT / TE_OUT  out  8/7/7  latched timing set.
- VEC_INDEX  out  ADDR_W  index of the vector currently applied.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-clock pulse on normal completion.
- ERR  out  1  configuration error; sticky until the next accepted START.

Behaviour:
- Reset values: all outputs 0 except PIN_RST, which is 1 and clears on the first clock after RST deasserts. State is IDLE and tick is 1.
- Registers: all outputs are registered; state and counters are updated on the rising edge of CLK.
- IDLE:
  - On START, latch the four config inputs, clear ERR, and go to CHECK.
  - START while BUSY is ignored.
- CHECK: the timing set is valid only if all of the following hold:
  - CL >= 3;
  - 1 <= LE < TE <= CL;
  - NUM_VECTORS >= 1 and NUM_VECTORS <= 2^ADDR_W.
  - Invalid: set ERR = 1 and go to IDLE. No VEC_RD is issued and PIN_EN stays 0.
  - Valid: go to PRIME.
- PRIME (1 clock): PIN_RST = 1, VEC_RD = 1, VEC_ADDR = 0. Next state LOAD.
- LOAD (1 clock):
  - Capture VEC_DATA into PIN_D/PIN_FF and set VEC_INDEX = 0.
  - If NUM_VECTORS > 1, issue VEC_RD at address 1.
  - Next state RUN with tick = 1.
- RUN, every clock:
  - PIN_EN = 1; tick advances 1..CL and wraps to 1, matching the pin registers' counter.
  - tick == 2: a prefetch read issued at the previous tick 1 is captured into the prefetch register.
  - tick == CL, more vectors remain: transfer prefetch to PIN_D/PIN_FF, increment VEC_INDEX, wrap tick to 1.
  - tick == 1 after a wrap: if index+1 < NUM_VECTORS, issue VEC_RD for index+1.
  - tick == CL on the last vector: go to DONE_ST.
- Vector timing: each vector is held for exactly CL clocks, so PIN_EN is high for NUM_VECTORS*CL clocks.
- DONE_ST (1 clock): PIN_EN = 0, DONE = 1, then IDLE. PIN_D, PIN_FF and VEC_INDEX hold their last values.
- ABORT in CHECK, PRIME, LOAD or RUN:
  - Next clock: state IDLE, PIN_EN = 0, PIN_RST = 1 for 1 clock.
  - No DONE pulse; ERR is unchanged.
- Simultaneous events:
  - RST overrides everything.
  - ABORT overrides a tick == CL transition.
  - START together with ABORT in IDLE: START wins.
- RST mid-run: return to reset values on the next edge; no DONE pulse.
- Widths: tick is 8 bits and compared directly with CL. The index compare uses ADDR_W+1 bits so that NUM_VECTORS = 2^ADDR_W does not wrap.

Decomposition:
- Shared package:
  - state encoding: IDLE, CHECK, PRIME, LOAD, RUN, DONE_ST;
  - force-format codes R0=00, R1=01, DNRZ_L=10, DNRZ_T=11;
  - VEC_DATA field offsets.
- Sub-module tester_tick_counter: counts 1..CL with enable, synchronous load-to-1 and wrap flag. It is also usable by other tester timing blocks.

Test Plan:
- Normal run, CL=4, LE=1, TE=3, NUM=3, vectors 0xA5/0x3C/0xFF with FF=DNRZ_L -> PIN_EN high for exactly 12 clocks; PIN_D changes only on wrap clocks; VEC_RD at addresses 0, 1, 2; DONE pulses on the clock after the 12th; BUSY then falls.
- Invalid configuration, LE=3, TE=3 -> ERR=1 two clocks after START; no VEC_RD; PIN_EN never rises; the next valid START clears ERR.
- NUM=1, CL=3 -> exactly one VEC_RD; PIN_EN high for 3 clocks; DONE follows.
- ABORT during vector 1 at tick 2 -> next clock PIN_EN=0, PIN_RST=1 for one clock, BUSY=0, no DONE; a subsequent START runs normally.
- RST asserted mid-RUN -> all outputs at reset values after the edge, PIN_RST=1; the FSM restarts cleanly on the next START.
- START pulses during RUN -> ignored, with no change to the latched CL/LE/TE; back-to-back START on the clock after DONE is accepted.

Source files
------------

// File: rtl/vector_sequencer_pkg.sv
// Shared definitions for the vector sequencer and related tester timing blocks.
//   - sequencer state encoding
//   - per-pin force-format codes
//   - timing-set field widths and the minimum legal cycle length
//   - VEC_DATA field offset helpers (data bit and force-format pair per pin)
package vector_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PRIME   = 3'd2,
        LOAD    = 3'd3,
        RUN     = 3'd4,
        DONE_ST = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        FF_R0     = 2'b00,
        FF_R1     = 2'b01,
        FF_DNRZ_L = 2'b10,
        FF_DNRZ_T = 2'b11
    } force_fmt_t;

    localparam int         CL_W   = 8;
    localparam int         EDGE_W = 7;
    localparam logic [7:0] CL_MIN = 8'd3;

    // Bit position of pin's data bit inside a vector word.
    function automatic int d_bit(input int pin);
        return pin;
    endfunction

    // LSB of pin's 2-bit force-format code inside a vector word.
    function automatic int ff_lsb(input int num_pins, input int pin);
        return num_pins + 2 * pin;
    endfunction

endpackage

// File: rtl/tester_tick_counter.sv
// Tester-cycle tick counter: counts 1..cycle_length and wraps back to 1.
// Ports:
//   CLK, RST      clock, synchronous active-high reset (tick returns to 1)
//   en            advance the tick this clock
//   load          force the tick to 1 (has priority over en)
//   cycle_length  last tick value of a tester cycle
//   tick          current tick, 1-based
//   wrap          high while tick == cycle_length
module tester_tick_counter #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] cycle_length,
    output logic [W-1:0] tick,
    output logic         wrap
);

    assign wrap = (tick == cycle_length);

    always_ff @(posedge CLK) begin
        if (RST) begin
            tick <= W'(1);
        end else if (load) begin
            tick <= W'(1);
        end else if (en) begin
            tick <= wrap ? W'(1) : tick + W'(1);
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// Vector sequencer: validates a latched timing set, then streams vectors from a
// synchronous vector RAM into the pin bank, one vector per tester cycle.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   START, ABORT              host control pulses
//   CYCLE_LENGTH/LEADING_EDGE/TRAILING_EDGE/NUM_VECTORS  run configuration
//   VEC_RD, VEC_ADDR, VEC_DATA  vector RAM read port (data one clock after read)
//   PIN_EN, PIN_RST, PIN_D, PIN_FF  pin bank control and applied vector
//   CL_OUT, LE_OUT, TE_OUT    latched timing set
//   VEC_INDEX                 index of the applied vector
//   BUSY, DONE, ERR           run status
//
// state   | meaning
// IDLE    | waiting for START
// CHECK   | validating the latched timing set
// PRIME   | pin bank reset, read of vector 0
// LOAD    | vector 0 captured, read of vector 1
// RUN     | pins enabled, one vector per CL clocks with prefetch
// DONE_ST | one-clock completion pulse
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int NUM_PINS = 8,
    parameter int ADDR_W   = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    ABORT,
    input  logic [CL_W-1:0]         CYCLE_LENGTH,
    input  logic [EDGE_W-1:0]       LEADING_EDGE,
    input  logic [EDGE_W-1:0]       TRAILING_EDGE,
    input  logic [ADDR_W:0]         NUM_VECTORS,
    output logic                    VEC_RD,
    output logic [ADDR_W-1:0]       VEC_ADDR,
    input  logic [3*NUM_PINS-1:0]   VEC_DATA,
    output logic                    PIN_EN,
    output logic                    PIN_RST,
    output logic [NUM_PINS-1:0]     PIN_D,
    output logic [2*NUM_PINS-1:0]   PIN_FF,
    output logic [CL_W-1:0]         CL_OUT,
    output logic [EDGE_W-1:0]       LE_OUT,
    output logic [EDGE_W-1:0]       TE_OUT,
    output logic [ADDR_W-1:0]       VEC_INDEX,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR
);

    localparam logic [ADDR_W:0] NUM_MAX = {1'b1, {ADDR_W{1'b0}}};

    seq_state_t              state, state_nxt;
    logic [ADDR_W:0]         num_lat, num_nxt;
    logic [3*NUM_PINS-1:0]   prefetch, prefetch_nxt;
    logic                    rd_pending;

    logic                    vec_rd_nxt, pin_en_nxt, pin_rst_nxt, done_nxt, err_nxt;
    logic [ADDR_W-1:0]       vec_addr_nxt, vec_index_nxt;
    logic [NUM_PINS-1:0]     pin_d_nxt;
    logic [2*NUM_PINS-1:0]   pin_ff_nxt;
    logic [CL_W-1:0]         cl_nxt;
    logic [EDGE_W-1:0]       le_nxt, te_nxt;

    logic [NUM_PINS-1:0]     ram_d, pre_d;
    logic [2*NUM_PINS-1:0]   ram_ff, pre_ff;
    logic [ADDR_W:0]         idx_p1, idx_p2;
    logic                    cfg_valid;

    logic [CL_W-1:0]         tick;
    logic                    tick_wrap;

    tester_tick_counter #(.W(CL_W)) u_tick (
        .CLK          (CLK),
        .RST          (RST),
        .en           (state == RUN),
        .load         (state != RUN),
        .cycle_length (CL_OUT),
        .tick         (tick),
        .wrap         (tick_wrap)
    );

    // Split RAM output and prefetch register into per-pin data/format fields.
    always_comb begin
        ram_d  = '0;
        ram_ff = '0;
        pre_d  = '0;
        pre_ff = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            ram_d[i]         = VEC_DATA[d_bit(i)];
            ram_ff[2*i +: 2] = VEC_DATA[ff_lsb(NUM_PINS, i) +: 2];
            pre_d[i]         = prefetch[d_bit(i)];
            pre_ff[2*i +: 2] = prefetch[ff_lsb(NUM_PINS, i) +: 2];
        end
    end

    // Index arithmetic carries one extra bit so a full 2^ADDR_W run cannot wrap.
    assign idx_p1 = {1'b0, VEC_INDEX} + (ADDR_W+1)'(1);
    assign idx_p2 = {1'b0, VEC_INDEX} + (ADDR_W+1)'(2);

    assign cfg_valid = (CL_OUT >= CL_MIN)
                    && (LE_OUT != '0)
                    && (LE_OUT < TE_OUT)
                    && ({1'b0, TE_OUT} <= CL_OUT)
                    && (num_lat != '0)
                    && (num_lat <= NUM_MAX);

    always_comb begin
        state_nxt     = state;
        vec_rd_nxt    = 1'b0;
        vec_addr_nxt  = VEC_ADDR;
        pin_en_nxt    = 1'b0;
        pin_rst_nxt   = 1'b0;
        pin_d_nxt     = PIN_D;
        pin_ff_nxt    = PIN_FF;
        vec_index_nxt = VEC_INDEX;
        done_nxt      = 1'b0;
        err_nxt       = ERR;
        cl_nxt        = CL_OUT;
        le_nxt        = LE_OUT;
        te_nxt        = TE_OUT;
        num_nxt       = num_lat;
        prefetch_nxt  = prefetch;

        if (ABORT && (state inside {CHECK, PRIME, LOAD, RUN})) begin
            state_nxt   = IDLE;
            pin_rst_nxt = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (START) begin
                        cl_nxt    = CYCLE_LENGTH;
                        le_nxt    = LEADING_EDGE;
                        te_nxt    = TRAILING_EDGE;
                        num_nxt   = NUM_VECTORS;
                        err_nxt   = 1'b0;
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (!cfg_valid) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt    = PRIME;
                        pin_rst_nxt  = 1'b1;
                        vec_rd_nxt   = 1'b1;
                        vec_addr_nxt = '0;
                    end
                end
                PRIME: begin
                    state_nxt    = LOAD;
                    vec_rd_nxt   = (num_lat > (ADDR_W+1)'(1));
                    vec_addr_nxt = ADDR_W'(1);
                end
                LOAD: begin
                    pin_d_nxt     = ram_d;
                    pin_ff_nxt    = ram_ff;
                    vec_index_nxt = '0;
                    pin_en_nxt    = 1'b1;
                    state_nxt     = RUN;
                end
                RUN: begin
                    pin_en_nxt = 1'b1;
                    // Data for a read issued on the previous clock is valid now.
                    if (rd_pending) begin
                        prefetch_nxt = VEC_DATA;
                    end
                    if (tick_wrap) begin
                        if (idx_p1 >= num_lat) begin
                            pin_en_nxt = 1'b0;
                            done_nxt   = 1'b1;
                            state_nxt  = DONE_ST;
                        end else begin
                            pin_d_nxt     = pre_d;
                            pin_ff_nxt    = pre_ff;
                            vec_index_nxt = idx_p1[ADDR_W-1:0];
                            // Fetch the vector after the one now being applied.
                            vec_rd_nxt    = (idx_p2 < num_lat);
                            vec_addr_nxt  = idx_p2[ADDR_W-1:0];
                        end
                    end
                end
                DONE_ST: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            num_lat    <= '0;
            prefetch   <= '0;
            rd_pending <= 1'b0;
            VEC_RD     <= 1'b0;
            VEC_ADDR   <= '0;
            PIN_EN     <= 1'b0;
            PIN_RST    <= 1'b1;
            PIN_D      <= '0;
            PIN_FF     <= '0;
            CL_OUT     <= '0;
            LE_OUT     <= '0;
            TE_OUT     <= '0;
            VEC_INDEX  <= '0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            state      <= state_nxt;
            num_lat    <= num_nxt;
            prefetch   <= prefetch_nxt;
            rd_pending <= VEC_RD;
            VEC_RD     <= vec_rd_nxt;
            VEC_ADDR   <= vec_addr_nxt;
            PIN_EN     <= pin_en_nxt;
            PIN_RST    <= pin_rst_nxt;
            PIN_D      <= pin_d_nxt;
            PIN_FF     <= pin_ff_nxt;
            CL_OUT     <= cl_nxt;
            LE_OUT     <= le_nxt;
            TE_OUT     <= te_nxt;
            VEC_INDEX  <= vec_index_nxt;
            BUSY       <= (state_nxt != IDLE);
            DONE       <= done_nxt;
            ERR        <= err_nxt;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer. A behavioural RAM supplies vectors;
// expected outputs for every clock of a run are derived from the run timeline:
// START accepted, CHECK, PRIME, LOAD, then NUM*CL clocks of RUN, then DONE.
`timescale 1ns/1ps
module tb_vector_sequencer;
    import vector_sequencer_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        ABORT = 1'b0;
    logic [7:0]  CYCLE_LENGTH = '0;
    logic [6:0]  LEADING_EDGE = '0;
    logic [6:0]  TRAILING_EDGE = '0;
    logic [10:0] NUM_VECTORS = '0;
    logic        VEC_RD;
    logic [9:0]  VEC_ADDR;
    logic [23:0] VEC_DATA;
    logic        PIN_EN, PIN_RST;
    logic [7:0]  PIN_D;
    logic [15:0] PIN_FF;
    logic [7:0]  CL_OUT;
    logic [6:0]  LE_OUT, TE_OUT;
    logic [9:0]  VEC_INDEX;
    logic        BUSY, DONE, ERR;

    int errors = 0;
    int checks = 0;

    logic [23:0] mem [0:1023];
    logic [23:0] ram_q = '0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (VEC_RD) ram_q <= mem[VEC_ADDR];
    assign VEC_DATA = ram_q;

    vector_sequencer #(.NUM_PINS(8), .ADDR_W(10)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
        .CYCLE_LENGTH(CYCLE_LENGTH), .LEADING_EDGE(LEADING_EDGE),
        .TRAILING_EDGE(TRAILING_EDGE), .NUM_VECTORS(NUM_VECTORS),
        .VEC_RD(VEC_RD), .VEC_ADDR(VEC_ADDR), .VEC_DATA(VEC_DATA),
        .PIN_EN(PIN_EN), .PIN_RST(PIN_RST), .PIN_D(PIN_D), .PIN_FF(PIN_FF),
        .CL_OUT(CL_OUT), .LE_OUT(LE_OUT), .TE_OUT(TE_OUT),
        .VEC_INDEX(VEC_INDEX), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) mem[i] = 24'($urandom);
    endtask

    // Starts a run (called at a negedge) and checks every clock against the
    // timeline model. stop_kind: 0 none, 1 ABORT, 2 RST, applied during
    // clock stop_k. spur_k: clock in which a stray START with new config is sent.
    task automatic run_vectors(input logic [7:0] cl, input logic [6:0] le, input logic [6:0] te,
                               input logic [10:0] num, input int stop_k, input int stop_kind,
                               input int spur_k);
        bit          valid;
        int          kd, last_k, v;
        bit          e_rd;
        logic [9:0]  e_addr;
        logic [23:0] w;
        valid  = (cl >= 3) && (le >= 1) && (le < te) && ({1'b0, te} <= cl)
                 && (num >= 1) && (num <= 11'd1024);
        kd     = 3 + int'(num) * int'(cl);
        last_k = valid ? kd + 1 : 3;
        CYCLE_LENGTH  = cl;
        LEADING_EDGE  = le;
        TRAILING_EDGE = te;
        NUM_VECTORS   = num;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (int k = 0; k <= last_k; k++) begin
            if (!valid) begin
                checks++; if (BUSY !== (k == 0)) begin errors++; $display("FAIL inv_busy k=%0d got=%b exp=%b", k, BUSY, (k == 0)); end
                checks++; if (ERR !== (k >= 1)) begin errors++; $display("FAIL inv_err k=%0d got=%b exp=%b", k, ERR, (k >= 1)); end
                checks++; if (VEC_RD !== 1'b0) begin errors++; $display("FAIL inv_rd k=%0d got=%b exp=0", k, VEC_RD); end
                checks++; if (PIN_EN !== 1'b0) begin errors++; $display("FAIL inv_en k=%0d got=%b exp=0", k, PIN_EN); end
                checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL inv_done k=%0d got=%b exp=0", k, DONE); end
            end else begin
                v = (k < 3) ? 0 : (k - 3) / int'(cl);
                if (v > int'(num) - 1) v = int'(num) - 1;
                w = mem[v];
                e_rd   = (k == 1) || (k == 2 && num > 1)
                         || (k >= 3 && k < kd && ((k - 3) % int'(cl)) == 0 && v >= 1 && v + 1 < int'(num));
                e_addr = (k == 1) ? 10'd0 : (k == 2) ? 10'd1 : 10'(v + 1);
                checks++; if (BUSY !== (k <= kd)) begin errors++; $display("FAIL busy k=%0d got=%b exp=%b", k, BUSY, (k <= kd)); end
                checks++; if (PIN_EN !== (k >= 3 && k < kd)) begin errors++; $display("FAIL pin_en k=%0d got=%b exp=%b", k, PIN_EN, (k >= 3 && k < kd)); end
                checks++; if (DONE !== (k == kd)) begin errors++; $display("FAIL done k=%0d got=%b exp=%b", k, DONE, (k == kd)); end
                checks++; if (PIN_RST !== (k == 1)) begin errors++; $display("FAIL pin_rst k=%0d got=%b exp=%b", k, PIN_RST, (k == 1)); end
                checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL err k=%0d got=%b exp=0", k, ERR); end
                checks++; if (VEC_RD !== e_rd) begin errors++; $display("FAIL vec_rd k=%0d got=%b exp=%b", k, VEC_RD, e_rd); end
                if (e_rd) begin
                    checks++; if (VEC_ADDR !== e_addr) begin errors++; $display("FAIL vec_addr k=%0d got=%0d exp=%0d", k, VEC_ADDR, e_addr); end
                end
                if (k >= 3) begin
                    checks++; if (PIN_D !== w[7:0]) begin errors++; $display("FAIL pin_d k=%0d got=%h exp=%h", k, PIN_D, w[7:0]); end
                    checks++; if (PIN_FF !== w[23:8]) begin errors++; $display("FAIL pin_ff k=%0d got=%h exp=%h", k, PIN_FF, w[23:8]); end
                    checks++; if (VEC_INDEX !== 10'(v)) begin errors++; $display("FAIL vec_index k=%0d got=%0d exp=%0d", k, VEC_INDEX, v); end
                end
                if (k <= kd) begin
                    checks++; if ({CL_OUT, LE_OUT, TE_OUT} !== {cl, le, te}) begin errors++; $display("FAIL timing_set k=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, CL_OUT, LE_OUT, TE_OUT, cl, le, te); end
                end
            end
            if (k == spur_k) begin
                START         = 1'b1;
                CYCLE_LENGTH  = 8'($urandom_range(3, 40));
                LEADING_EDGE  = 7'($urandom_range(1, 2));
                TRAILING_EDGE = 7'($urandom_range(3, 4));
                NUM_VECTORS   = 11'($urandom_range(1, 9));
            end else begin
                START = 1'b0;
            end
            if (k == stop_k) begin
                if (stop_kind == 1) ABORT = 1'b1; else RST = 1'b1;
                @(negedge CLK);
                ABORT = 1'b0;
                RST   = 1'b0;
                START = 1'b0;
                checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", BUSY); end
                checks++; if (PIN_EN !== 1'b0) begin errors++; $display("FAIL stop_en got=%b exp=0", PIN_EN); end
                checks++; if (PIN_RST !== 1'b1) begin errors++; $display("FAIL stop_pin_rst got=%b exp=1", PIN_RST); end
                checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL stop_done got=%b exp=0", DONE); end
                checks++; if (VEC_RD !== 1'b0) begin errors++; $display("FAIL stop_rd got=%b exp=0", VEC_RD); end
                checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL stop_err got=%b exp=0", ERR); end
                if (stop_kind == 2) begin
                    checks++; if ({PIN_D, PIN_FF, VEC_INDEX, VEC_ADDR} !== '0) begin errors++; $display("FAIL rst_data got=%h/%h/%0d/%0d exp=0", PIN_D, PIN_FF, VEC_INDEX, VEC_ADDR); end
                    checks++; if ({CL_OUT, LE_OUT, TE_OUT} !== '0) begin errors++; $display("FAIL rst_timing got=%0d/%0d/%0d exp=0", CL_OUT, LE_OUT, TE_OUT); end
                end
                @(negedge CLK);
                checks++; if (PIN_RST !== 1'b0) begin errors++; $display("FAIL stop_pin_rst_clear got=%b exp=0", PIN_RST); end
                checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL stop_idle got=%b exp=0", BUSY); end
                return;
            end
            if (k < last_k) @(negedge CLK);
        end
        START = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle(3);
        checks++; if ({VEC_RD, VEC_ADDR, PIN_EN, PIN_D, PIN_FF} !== '0) begin errors++; $display("FAIL reset_outs got=%b/%0d/%b/%h/%h exp=0", VEC_RD, VEC_ADDR, PIN_EN, PIN_D, PIN_FF); end
        checks++; if ({CL_OUT, LE_OUT, TE_OUT, VEC_INDEX, BUSY, DONE, ERR} !== '0) begin errors++; $display("FAIL reset_status got=%0d/%0d/%0d/%0d/%b%b%b exp=0", CL_OUT, LE_OUT, TE_OUT, VEC_INDEX, BUSY, DONE, ERR); end
        checks++; if (PIN_RST !== 1'b1) begin errors++; $display("FAIL reset_pin_rst got=%b exp=1", PIN_RST); end
        RST = 1'b0;
        @(negedge CLK);
        checks++; if (PIN_RST !== 1'b0) begin errors++; $display("FAIL reset_pin_rst_clear got=%b exp=0", PIN_RST); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_normal_run();
        logic [1:0]  fmt;
        logic [15:0] ff_all;
        fmt    = FF_DNRZ_L;
        ff_all = {8{fmt}};
        mem[0] = {ff_all, 8'hA5};
        mem[1] = {ff_all, 8'h3C};
        mem[2] = {ff_all, 8'hFF};
        mem[3] = 24'($urandom);
        run_vectors(8'd4, 7'd1, 7'd3, 11'd3, -1, 0, -1);
        idle(2);
    endtask

    task automatic test_invalid_config();
        run_vectors(8'd4, 7'd3, 7'd3, 11'd2, -1, 0, -1);
        idle(2);
        checks++; if (ERR !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", ERR); end
        fill_random(4);
        run_vectors(8'd5, 7'd2, 7'd4, 11'd2, -1, 0, -1);
        run_vectors(8'd2, 7'd1, 7'd2, 11'd1, -1, 0, -1);
        run_vectors(8'd5, 7'd0, 7'd2, 11'd1, -1, 0, -1);
        run_vectors(8'd5, 7'd1, 7'd6, 11'd1, -1, 0, -1);
        run_vectors(8'd5, 7'd1, 7'd5, 11'd0, -1, 0, -1);
        run_vectors(8'd5, 7'd1, 7'd5, 11'd1025, -1, 0, -1);
        run_vectors(8'd3, 7'd1, 7'd3, 11'd2, -1, 0, -1);
        idle(1);
    endtask

    task automatic test_single_vector();
        fill_random(2);
        run_vectors(8'd3, 7'd1, 7'd2, 11'd1, -1, 0, -1);
        idle(1);
    endtask

    task automatic test_abort();
        fill_random(4);
        run_vectors(8'd4, 7'd1, 7'd3, 11'd3, 3 + 4 + 1, 1, -1);
        run_vectors(8'd4, 7'd1, 7'd3, 11'd3, -1, 0, -1);
        idle(1);
        run_vectors(8'd4, 7'd1, 7'd3, 11'd3, 0, 1, -1);
        run_vectors(8'd4, 7'd1, 7'd3, 11'd3, 2, 1, -1);
        run_vectors(8'd4, 7'd1, 7'd3, 11'd3, 3 + 2 * 4 - 1, 1, -1);
        idle(1);
    endtask

    task automatic test_reset_mid_run();
        fill_random(4);
        run_vectors(8'd5, 7'd2, 7'd4, 11'd4, 3 + 5 + 2, 2, -1);
        idle(1);
        run_vectors(8'd5, 7'd2, 7'd4, 11'd4, -1, 0, -1);
        idle(1);
    endtask

    task automatic test_back_to_back();
        fill_random(4);
        run_vectors(8'd6, 7'd2, 7'd5, 11'd3, -1, 0, 3 + 6 + 2);
        run_vectors(8'd3, 7'd1, 7'd3, 11'd2, -1, 0, 4);
        run_vectors(8'd7, 7'd3, 7'd7, 11'd4, -1, 0, -1);
        idle(2);
    endtask

    task automatic test_max_vectors();
        fill_random(1024);
        run_vectors(8'd3, 7'd1, 7'd2, 11'd1024, -1, 0, -1);
        idle(1);
    endtask

    task automatic test_random();
        logic [7:0]  cl;
        logic [6:0]  le, te;
        logic [10:0] num;
        int          r, stop_k, kind;
        for (int it = 0; it < 30; it++) begin
            cl  = 8'($urandom_range(3, 9));
            te  = 7'($urandom_range(2, int'(cl)));
            le  = 7'($urandom_range(1, int'(te) - 1));
            num = 11'($urandom_range(1, 5));
            r   = int'($urandom_range(0, 9));
            stop_k = -1;
            kind   = 0;
            if (r == 0) le = te;
            else if (r == 1) begin
                stop_k = int'($urandom_range(0, 3 + int'(num) * int'(cl) - 1));
                kind   = 1;
            end else if (r == 2) begin
                stop_k = int'($urandom_range(0, 3 + int'(num) * int'(cl)));
                kind   = 2;
            end
            fill_random(int'(num) + 1);
            run_vectors(cl, le, te, num, stop_k, kind, -1);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        test_reset();
        test_normal_run();
        test_invalid_config();
        test_single_vector();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        test_max_vectors();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
